// File: rtl/seg_rotation_decoder.sv
// seg_rotation_decoder: recovers step index, direction and lap count from a rotating single-segment 7-seg animation
// Ports: clk; reset (async, active-low); seg[6:0] abcdefg, an[3:0] one-hot digit enables (an[3]=leftmost), both async to clk;
//        step/step_valid last accepted step and its pulse; dir/dir_valid rotation direction; unknown, seq_err pulses;
//        stall level after timeout; lap_count completed revolutions mod 256.
module seg_rotation_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter logic [6:0]  TOP_PAT        = 7'b1100011,
  parameter logic [6:0]  BOT_PAT        = 7'b0011101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [2:0] step,
  output logic       step_valid,
  output logic       dir,
  output logic       dir_valid,
  output logic       unknown,
  output logic       seq_err,
  output logic       stall,
  output logic [7:0] lap_count
);
  localparam logic [1:0]  S_IDLE       = 2'd0;
  localparam logic [1:0]  S_FIRST      = 2'd1;
  localparam logic [1:0]  S_LOCKED     = 2'd2;
  localparam logic [7:0]  STABLE_MAX   = 8'(STABLE_CYCLES);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [10:0] sync1_q, sync2_q, prev_q;
  logic [7:0]  cnt_q, cnt_d, lap_q, lap_d;
  logic [31:0] timer_q, timer_d;
  logic [1:0]  state_q, state_d;
  logic [2:0]  step_q, step_d, s, nxt, prv;
  logic        step_valid_q, step_valid_d, dir_q, dir_d, dir_valid_q, dir_valid_d;
  logic        unknown_q, unknown_d, seq_err_q, seq_err_d, stall_q, stall_d;
  logic        same, fire, blank, one_hot, top, bot, cand, inc, dec;
  logic [6:0]  pseg;
  logic [3:0]  pan;
  always_comb begin
    pseg    = sync2_q[10:4];
    pan     = sync2_q[3:0];
    same    = sync2_q == prev_q;
    // fire on the increment that reaches STABLE_CYCLES so the FSM reacts on that same edge
    fire    = same && cnt_q == STABLE_MAX - 8'd1;
    cnt_d   = !same ? 8'd0 : (cnt_q == STABLE_MAX ? cnt_q : cnt_q + 8'd1);
    blank   = pan == 4'b0000;
    one_hot = pan == 4'b1000 || pan == 4'b0100 || pan == 4'b0010 || pan == 4'b0001;
    top     = one_hot && pseg == TOP_PAT;
    bot     = one_hot && pseg == BOT_PAT;
    s       = top ? (pan[3] ? 3'd0 : pan[2] ? 3'd1 : pan[1] ? 3'd2 : 3'd3)
                  : (pan[0] ? 3'd4 : pan[1] ? 3'd5 : pan[2] ? 3'd6 : 3'd7);
    // a re-settle onto the current step is not a new step once tracking has started
    cand    = fire && (top || bot) && !(s == step_q && state_q != S_IDLE);
    nxt     = step_q + 3'd1;
    prv     = step_q - 3'd1;
    inc     = s == nxt;
    dec     = s == prv;
    state_d      = state_q;
    step_d       = step_q;
    step_valid_d = 1'b0;
    dir_d        = dir_q;
    dir_valid_d  = dir_valid_q;
    unknown_d    = fire && !blank && !(top || bot);
    seq_err_d    = 1'b0;
    stall_d      = stall_q;
    lap_d        = lap_q;
    timer_d      = state_q == S_IDLE ? timer_q : timer_q + 32'd1;
    if (cand) begin
      step_d       = s;
      step_valid_d = 1'b1;
      stall_d      = 1'b0;
      timer_d      = 32'd0;
      if (state_q == S_IDLE) begin
        state_d = S_FIRST;
      end else if (inc || dec) begin
        dir_d       = inc;
        dir_valid_d = 1'b1;
        state_d     = S_LOCKED;
        lap_d       = lap_q + {7'd0, (inc && step_q == 3'd7) || (dec && step_q == 3'd0)};
      end else begin
        seq_err_d   = 1'b1;
        dir_valid_d = 1'b0;
        state_d     = S_FIRST;
      end
    end else if (state_q != S_IDLE && timer_q == TIMEOUT_LAST) begin
      stall_d     = 1'b1;
      dir_valid_d = 1'b0;
      state_d     = S_IDLE;
      timer_d     = 32'd0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      state_q      <= S_IDLE;
      step_q       <= '0;
      step_valid_q <= 1'b0;
      dir_q        <= 1'b0;
      dir_valid_q  <= 1'b0;
      unknown_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      stall_q      <= 1'b0;
      lap_q        <= '0;
    end else begin
      sync1_q      <= {seg, an};
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      state_q      <= state_d;
      step_q       <= step_d;
      step_valid_q <= step_valid_d;
      dir_q        <= dir_d;
      dir_valid_q  <= dir_valid_d;
      unknown_q    <= unknown_d;
      seq_err_q    <= seq_err_d;
      stall_q      <= stall_d;
      lap_q        <= lap_d;
    end
  end
  assign step       = step_q;
  assign step_valid = step_valid_q;
  assign dir        = dir_q;
  assign dir_valid  = dir_valid_q;
  assign unknown    = unknown_q;
  assign seq_err    = seq_err_q;
  assign stall      = stall_q;
  assign lap_count  = lap_q;
endmodule

// File: tb/tb_seg_rotation_decoder.sv
// tb_seg_rotation_decoder: scoreboard bench for seg_rotation_decoder
module tb_seg_rotation_decoder;
  localparam logic [6:0] TOP = 7'b1100011;
  localparam logic [6:0] BOT = 7'b0011101;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] seg = '0;
  logic [3:0] an = '0;
  logic [2:0] step;
  logic       step_valid, dir, dir_valid, unknown, seq_err, stall;
  logic [7:0] lap_count;
  typedef struct packed {
    logic [2:0] st;
    logic       d;
    logic       dv;
    logic       se;
    logic       sl;
    logic [7:0] lap;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int unk_cnt = 0;
  int lat, u0;
  seg_rotation_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .step(step), .step_valid(step_valid),
    .dir(dir), .dir_valid(dir_valid), .unknown(unknown), .seq_err(seq_err), .stall(stall),
    .lap_count(lap_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (unknown) unk_cnt++;
    if (seq_err && !step_valid) chk("seq_err_without_step", 32'(seq_err), 32'd0);
    if (step_valid) begin
      if (q.size() == 0) chk("unexpected_step_valid", 32'(step_valid), 32'd0);
      else begin
        e = q.pop_front();
        chk("step_tuple", 32'({step, dir, dir_valid, seq_err, stall, lap_count}), 32'(e));
      end
    end
  end
  task automatic put(input int s);
    seg = s < 4 ? TOP : BOT;
    an  = s < 4 ? 4'b1000 >> s : 4'b0001 << (s - 4);
  endtask
  task automatic present(input int s, input logic d, input logic dv, input logic se, input int lap,
                         input int extra, output int l);
    exp_t x;
    x.st = 3'(s); x.d = d; x.dv = dv; x.se = se; x.sl = 1'b0; x.lap = 8'(lap);
    q.push_back(x);
    put(s);
    l = 0;
    for (int k = 1; k <= 30 && l == 0; k++) begin
      @(posedge clk); #1;
      if (step_valid) l = k;
    end
    if (l == 0) chk("step_valid_timeout", 32'd0, 32'd1);
    repeat (extra) @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    chk("queue_drained", 32'(q.size()), 32'd0);
    reset = 1'b0; seg = '0; an = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({step, step_valid, dir, dir_valid, unknown, seq_err, stall, lap_count}), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    present(0, 0, 0, 0, 0, 12, lat);
    chk("first_latency", 32'(lat), 32'd7);
    for (int i = 1; i <= 8; i++) present(i % 8, 1, 1, 0, i / 8, 12, lat);
    chk("lap_after_rev", 32'(lap_count), 32'd1);
    do_reset;
    present(3, 0, 0, 0, 0, 12, lat);
    present(2, 0, 1, 0, 0, 12, lat);
    present(1, 0, 1, 0, 0, 12, lat);
    present(0, 0, 1, 0, 0, 12, lat);
    present(7, 0, 1, 0, 1, 12, lat);
    chk("dec_dir", 32'({dir, dir_valid}), 32'b01);
    do_reset;
    present(2, 0, 0, 0, 0, 12, lat);
    u0 = unk_cnt;
    seg = 7'b1111111; an = 4'b0010;
    repeat (3) @(posedge clk);
    #1 put(2);
    repeat (20) @(posedge clk);
    #1 chk("glitch_no_unknown", 32'(unk_cnt - u0), 32'd0);
    seg = 7'b1111111; an = 4'b0100;
    repeat (10) @(posedge clk);
    #1 chk("unknown_once", 32'(unk_cnt - u0), 32'd1);
    an = 4'b0000;
    repeat (10) @(posedge clk);
    #1 chk("blank_no_pulse", 32'(unk_cnt - u0), 32'd1);
    present(1, 0, 1, 0, 0, 12, lat);
    present(5, 0, 0, 1, 0, 12, lat);
    chk("seq_err_step", 32'({step, dir_valid}), 32'b1010);
    present(6, 1, 1, 0, 0, 12, lat);
    do_reset;
    present(4, 0, 0, 0, 0, 12, lat);
    present(5, 1, 1, 0, 0, 0, lat);
    repeat (999) @(posedge clk);
    #1 chk("no_stall_before_timeout", 32'(stall), 32'd0);
    @(posedge clk);
    #1 chk("stall_at_timeout", 32'({stall, dir_valid}), 32'b10);
    present(6, 1, 0, 0, 0, 12, lat);
    chk("stall_cleared", 32'(stall), 32'd0);
    present(7, 1, 1, 0, 0, 12, lat);
    do_reset;
    present(0, 0, 0, 0, 0, 12, lat);
    for (int i = 1; i <= 24; i++) present(i % 8, 1, 1, 0, i / 8, 12, lat);
    chk("three_laps", 32'(lap_count), 32'd3);
    put(1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("async_reset", 32'({step, step_valid, dir, dir_valid, unknown, seq_err, stall, lap_count}), 32'd0);
    seg = '0; an = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    present(3, 0, 0, 0, 0, 12, lat);
    chk("post_reset_latency", 32'(lat), 32'd7);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
